// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Drives the 2-bit select of a downstream 4:1 mux through channels 0..3,
//   holds each channel for DWELL cycles, latches the mux result bit at the end
//   of each dwell and publishes the four bits as one word with a one-cycle
//   valid pulse. Supports single-shot and continuous scanning.
//
//   Optional feature macro: MUX_SCAN_CHANGE_EN
//     defined   -> 'changed' port pulses with valid when the new word differs
//                  from the previous one (first word compares against 0).
//     undefined -> 'changed' port and its compare logic are absent.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   level, sampled only while idle, begins a scan
//   continuous  in   sampled at end of scan; 1 = rescan without idle gap
//   mux_out     in   result bit of the downstream mux
//   sel         out  [1:0] mux select
//   sample      out  [3:0] captured word, sample[i] = mux_out while sel==i
//   valid       out  one-cycle pulse marking a new sample word
//   busy        out  high whenever a scan is in progress
//   changed     out  (MUX_SCAN_CHANGE_EN only) new word differs from previous
module mux_scan_sequencer #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       mux_out,
    output logic [1:0] sel,
    output logic [3:0] sample,
    output logic       valid,
`ifdef MUX_SCAN_CHANGE_EN
    output logic       changed,
`endif
    output logic       busy
);

    localparam int unsigned SEL_W    = 2;
    localparam int unsigned WORD_W   = 4;
    localparam int unsigned SHADOW_W = 3;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(3);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SHADOW_W-1:0] shadow_q, shadow_d;
    logic [WORD_W-1:0]   sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic [WORD_W-1:0]   word_c;
`ifdef MUX_SCAN_CHANGE_EN
    logic                changed_q, changed_d;
`endif

    // Word completed by the channel-3 capture on this edge.
    assign word_c = {mux_out, shadow_q};

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
`ifdef MUX_SCAN_CHANGE_EN
        changed_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    sel_d   = '0;
                    cnt_d   = CNT_RELOAD;
                    busy_d  = 1'b1;
                end
            end
            ST_SCAN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (sel_q != SEL_LAST) begin
                    // Channels 0..2 park their bit in the shadow register.
                    case (sel_q)
                        2'd0:    shadow_d[0] = mux_out;
                        2'd1:    shadow_d[1] = mux_out;
                        default: shadow_d[2] = mux_out;
                    endcase
                    sel_d = sel_q + SEL_W'(1);
                    cnt_d = CNT_RELOAD;
                end else begin
                    // Channel 3 completes the word; wrap sel explicitly.
                    sample_d = word_c;
                    valid_d  = 1'b1;
`ifdef MUX_SCAN_CHANGE_EN
                    changed_d = (word_c != sample_q);
`endif
                    sel_d = '0;
                    if (continuous) begin
                        cnt_d = CNT_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                sel_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            shadow_q <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MUX_SCAN_CHANGE_EN
            changed_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
`ifdef MUX_SCAN_CHANGE_EN
            changed_q <= changed_d;
`endif
        end
    end

    assign sel    = sel_q;
    assign sample = sample_q;
    assign valid  = valid_q;
    assign busy   = busy_q;
`ifdef MUX_SCAN_CHANGE_EN
    assign changed = changed_q;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer. Two instances (DWELL=4 and
// DWELL=1) share the stimulus; each has its own behavioural model that counts
// elapsed cycles of a scan and derives sel/captures from that count.
module tb_mux_scan_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       continuous;
    logic [3:0] pat;

    logic       mux_w   [2];
    logic [1:0] sel_w   [2];
    logic [3:0] samp_w  [2];
    logic       valid_w [2];
    logic       busy_w  [2];
`ifdef MUX_SCAN_CHANGE_EN
    logic       chg_w   [2];
`endif

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int unsigned DW = (g == 0) ? 4 : 1;

        // Downstream mux: channel pattern indexed by the DUT's select.
        assign mux_w[g] = pat[sel_w[g]];

        mux_scan_sequencer #(.DWELL(DW), .CNT_W(8)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start),
            .continuous (continuous),
            .mux_out    (mux_w[g]),
            .sel        (sel_w[g]),
            .sample     (samp_w[g]),
            .valid      (valid_w[g]),
`ifdef MUX_SCAN_CHANGE_EN
            .changed    (chg_w[g]),
`endif
            .busy       (busy_w[g])
        );

        // Model: a scan is a run of 4*DW cycles; channel = elapsed/DW,
        // capture when elapsed is a multiple of DW, word done at 4*DW.
        int         el;
        logic       mb;
        logic [1:0] ms;
        logic [3:0] msamp;
        logic [3:0] caps;
        logic       mv;
        logic       mc;

        initial begin
            el = 0; mb = 1'b0; ms = 2'd0; msamp = 4'd0; caps = 4'd0;
            mv = 1'b0; mc = 1'b0;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    el = 0; mb = 1'b0; ms = 2'd0; msamp = 4'd0; caps = 4'd0;
                    mv = 1'b0; mc = 1'b0;
                end else begin
                    mv = 1'b0;
                    mc = 1'b0;
                    if (!mb) begin
                        if (start) begin
                            mb = 1'b1;
                            el = 0;
                        end
                    end else begin
                        el++;
                        if (el % DW == 0) begin
                            caps[el / DW - 1] = pat[el / DW - 1];
                            if (el == 4 * DW) begin
                                mv    = 1'b1;
                                mc    = (caps != msamp);
                                msamp = caps;
                                el    = 0;
                                if (!continuous) mb = 1'b0;
                            end
                        end
                    end
                    ms = mb ? 2'(el / DW) : 2'd0;
                end
            end
        end

        // Per-cycle compare against the model, away from the active edge.
        initial begin
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    chk($sformatf("sel[dw%0d]", DW),    int'(sel_w[g]),   int'(ms));
                    chk($sformatf("sample[dw%0d]", DW), int'(samp_w[g]),  int'(msamp));
                    chk($sformatf("valid[dw%0d]", DW),  int'(valid_w[g]), int'(mv));
                    chk($sformatf("busy[dw%0d]", DW),   int'(busy_w[g]),  int'(mb));
`ifdef MUX_SCAN_CHANGE_EN
                    chk($sformatf("changed[dw%0d]", DW), int'(chg_w[g]), int'(mc));
`endif
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int g, input int maxc, output int n);
        n = 0;
        while (!valid_w[g] && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!valid_w[g]) chk($sformatf("valid_timeout[%0d]", g), 0, 1);
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((busy_w[0] || busy_w[1]) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(busy_w[0] || busy_w[1]), 0);
    endtask

    task automatic chk_reset_state(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s_sel[%0d]", tag, g),    int'(sel_w[g]),   0);
            chk($sformatf("%s_sample[%0d]", tag, g), int'(samp_w[g]),  0);
            chk($sformatf("%s_valid[%0d]", tag, g),  int'(valid_w[g]), 0);
            chk($sformatf("%s_busy[%0d]", tag, g),   int'(busy_w[g]),  0);
        end
    endtask

    initial begin
        int n;
        int cnt;
        rst_n      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        pat        = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_state("por");

        // Single shot, DWELL=4: word lands 17 negedges after start is driven.
        pat   = 4'b0110;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!valid_w[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("single_latency", n, 17);
        chk("single_sample", int'(samp_w[0]), 4'b0110);
        chk("single_busy_fall", int'(busy_w[0]), 0);

        // start held in IDLE after a single shot restarts on the next edge.
        start = 1'b1;
        wait_valid(0, 40, n);
        chk("held_busy_low", int'(busy_w[0]), 0);
        @(negedge clk);
        chk("held_restart", int'(busy_w[0]), 1);
        start = 1'b0;
        wait_idle(60);

        // Continuous, DWELL=1: pattern changed after the first word.
        continuous = 1'b1;
        pat        = 4'b1011;
        pulse_start();
        wait_valid(1, 20, n);
        chk("cont_word1", int'(samp_w[1]), 4'b1011);
        pat = 4'b0100;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("cont_sel_%0d", i), int'(sel_w[1]), i % 4);
        end
        chk("cont_valid2", int'(valid_w[1]), 1);
        chk("cont_word2", int'(samp_w[1]), 4'b0100);
        continuous = 1'b0;
        wait_idle(60);

        // start re-pulsed mid-scan is ignored by the busy DWELL=4 instance.
        pat = 4'b1100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int i = 2; i <= 40; i++) begin
            if (i == 6) start = 1'b1;
            if (i == 7) start = 1'b0;
            @(negedge clk);
            if (valid_w[0]) cnt++;
        end
        chk("ignored_start_pulses", cnt, 1);
        wait_idle(60);

        // continuous dropped while sel==1: scan completes, then idle.
        pat        = 4'b1001;
        continuous = 1'b1;
        pulse_start();
        n = 0;
        while (sel_w[0] != 2'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drop_reach_sel1", int'(sel_w[0]), 1);
        continuous = 1'b0;
        cnt = 0;
        n   = 0;
        while (busy_w[0] && n < 40) begin
            @(negedge clk);
            n++;
            if (valid_w[0]) cnt++;
        end
        chk("drop_valid_count", cnt, 1);
        chk("drop_idle", int'(busy_w[0]), 0);
        chk("drop_word", int'(samp_w[0]), 4'b1001);
        wait_idle(60);

        // Reset mid-scan, between edges: outputs clear without a clock edge.
        pulse_start();
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef MUX_SCAN_CHANGE_EN
        // Change detect: 0000, 0000, 1000 after reset.
        pat = 4'b0000;
        pulse_start();
        wait_valid(0, 40, n);
        chk("chg_word1", int'(chg_w[0]), 0);
        wait_idle(60);
        pulse_start();
        wait_valid(0, 40, n);
        chk("chg_word2", int'(chg_w[0]), 0);
        wait_idle(60);
        pat = 4'b1000;
        pulse_start();
        wait_valid(0, 40, n);
        chk("chg_word3", int'(chg_w[0]), 1);
        chk("chg_word3_sample", int'(samp_w[0]), 4'b1000);
        wait_idle(60);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
